image_window_loader: RTL
========================

# image_window_loader

Parametrised successor to the image loader. Fetches a multi-channel square image from word-addressed memory one channel at a time into an internal frame buffer. Then streams every K×K stride-1 window of that channel to the convolution unit over a valid/ready handshake. Image size, channel count and base address are set at run time; maximum image size, kernel size and widths are parameters.

## Interface
- DATA_WIDTH, 16, pixel word width
- ADDR_WIDTH, 20, memory address width
- MAX_IMG, 32, largest supported image side
- MAX_CH, 8, largest supported channel count
- K, 5, window side (K ≥ 1, K ≤ MAX_IMG)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled in IDLE only
- img_size  in  $clog2(MAX_IMG+1)  image side S
- channels  in  $clog2(MAX_CH+1)  channel count C
- base_addr  in  ADDR_WIDTH  address of pixel (ch0,row0,col0)
- busy  out  1  high in LOAD and EMIT
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the start was rejected
- mem_rd_en  out  1  read request
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after its request
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts window
- window  out  DATA_WIDTH*K*K  row-major window; element kr*K+kc at bits [(kr*K+kc)*DATA_WIDTH +: DATA_WIDTH]
- win_ch, win_row, win_col  out  channel / top-left row / top-left column of current window

## Operation
- States: IDLE, LOAD, EMIT, DONE.
- Memory layout is channel-major: pixel (c,r,x) at base_addr + c·S² + r·S + x. Arithmetic is modulo 2^ADDR_WIDTH.
- IDLE, start=1:
  - Latch S, C, base_addr.
  - If S<K, S>MAX_IMG, C=0 or C>MAX_CH: go to DONE with err=1. No memory reads are issued.
  - Otherwise go to LOAD with channel 0.
- LOAD:
  - Issue S² consecutive reads, one per cycle, in raster order.
  - Each returning word is written to frame buffer position r·S+x.
  - After the last word is captured, go to EMIT with row=col=0.
- EMIT:
  - win_valid=1; window reflects buffer pixels (row+kr, col+kc).
  - On win_valid&&win_ready, col increments. At col=S−K it wraps to 0 and row increments.
  - After window (S−K, S−K) is accepted: if channel<C−1, increment channel and go to LOAD; else go to DONE.
- DONE: done=1 for one cycle (err as determined), then IDLE.
- start outside IDLE is ignored; inputs latched at start are unaffected by later input changes.
- Windows per channel: (S−K+1)².

## Timing
- Reset values:
  - State IDLE.
  - busy, done, err, mem_rd_en, win_valid = 0.
  - mem_addr, window, win_ch, win_row, win_col = 0.
  - Counters and buffer write pointer cleared (buffer contents need not be cleared).
- Reset asserted mid-operation aborts immediately. No done pulse; a new start is accepted after release.
- start accepted at edge E0:
  - mem_rd_en high for cycles E0+1 … E0+S² with sequential addresses.
  - First win_valid at E0+S²+2.
- Valid path: window and indices are stable while win_valid=1 and win_ready=0. A new window is presented the cycle after each accept. Back-to-back accepts yield one window per cycle.
- Channel reload: mem_rd_en begins the cycle after the final accept of the previous channel.
- Rejected start: done=err=1 in the cycle after E0.
- Normal completion: done=1 (err=0) the cycle after the last accept.
- busy: 1 from E0+1 until the DONE cycle (0 in DONE).

## Test plan
- K=3, S=4, C=1, base 0x00100, mem returns addr[15:0] -> 16 reads at 0x100–0x10F; 4 windows. First window elements 0x100,0x101,0x102,0x104,…,0x10A. Last window top-left 0x105. done then err=0.
- K=3, S=3, C=2, base 0 -> reads 0–8, one window (ch0), reads 9–17, one window (ch1, element0=9), single done pulse.
- Backpressure: win_ready low 5 cycles at second window -> window/win_col stay constant, then advance one per accept with no loss or duplication.
- K=3, img_size=2 (also channels=0) -> done=err=1 one cycle after start; mem_rd_en never asserted.
- Address wrap: base 0xFFFFC, S=3, K=3 -> addresses 0xFFFFC…0xFFFFF, 0x00000…0x00004.
- Reset pulse during LOAD, start pulses during EMIT -> all outputs return to reset values and no done pulse. A fresh start runs correctly. Mid-EMIT starts are ignored and leave latched S/C/base unchanged.

Source files
------------

// File: rtl/image_window_loader.sv
// Image window loader: fetches one channel of an S x S image into a frame buffer,
// then streams every K x K stride-1 window of it over a valid/ready handshake.
module image_window_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int MAX_IMG    = 32,
    parameter int MAX_CH     = 8,
    parameter int K          = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [$clog2(MAX_IMG+1)-1:0]    img_size,
    input  logic [$clog2(MAX_CH+1)-1:0]     channels,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [DATA_WIDTH*K*K-1:0]       window,
    output logic [$clog2(MAX_CH+1)-1:0]     win_ch,
    output logic [$clog2(MAX_IMG+1)-1:0]    win_row,
    output logic [$clog2(MAX_IMG+1)-1:0]    win_col
);

    localparam int SW = $clog2(MAX_IMG + 1);
    localparam int CW = $clog2(MAX_CH + 1);
    localparam int IW = (MAX_IMG > 1) ? $clog2(MAX_IMG) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t                  state;
    logic [SW-1:0]           s_reg;
    logic [CW-1:0]           c_reg;
    logic [SW-1:0]           rd_row, rd_col;
    logic [SW-1:0]           wr_row, wr_col;
    logic                    cap_valid;
    logic [DATA_WIDTH-1:0]   fbuf [MAX_IMG][MAX_IMG];

    logic [SW-1:0]           s_last, win_last;
    logic                    rd_last, wr_last, col_last, row_last;
    logic                    buf_we, start_bad;
    logic [SW-1:0]           nxt_row, nxt_col;
    logic [DATA_WIDTH*K*K-1:0] window_nxt;

    assign s_last    = s_reg - SW'(1);
    assign win_last  = s_reg - SW'(K);
    assign rd_last   = (rd_row == s_last) && (rd_col == s_last);
    assign wr_last   = (wr_row == s_last) && (wr_col == s_last);
    assign col_last  = (win_col == win_last);
    assign row_last  = (win_row == win_last);
    assign buf_we    = (state == LOAD) && cap_valid;
    assign start_bad = (img_size < SW'(K)) || (img_size > SW'(MAX_IMG)) ||
                       (channels == '0) || (channels > CW'(MAX_CH));

    // Position of the window presented after the next update; (0,0) when entering EMIT.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        nxt_row = '0;
        nxt_col = '0;
        if (state == EMIT) begin
            if (!col_last) begin
                nxt_row = win_row;
                nxt_col = win_col + SW'(1);
            end else if (!row_last) begin
                nxt_row = win_row + SW'(1);
            end
        end
    end

    // The pixel being captured this cycle is forwarded so the first window needs no extra cycle.
    always_comb begin
        window_nxt = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                if (buf_we && (wr_row == nxt_row + SW'(kr)) && (wr_col == nxt_col + SW'(kc)))
                    window_nxt[(kr*K+kc)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                else
                    window_nxt[(kr*K+kc)*DATA_WIDTH +: DATA_WIDTH] =
                        fbuf[IW'(nxt_row + SW'(kr))][IW'(nxt_col + SW'(kc))];
            end
        end
    end

    // NOTE: the frame buffer has no reset; every location read in EMIT is written in LOAD first.
    always_ff @(posedge clk) begin
        if (buf_we)
            fbuf[IW'(wr_row)][IW'(wr_col)] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            win_valid <= 1'b0;
            window    <= '0;
            win_ch    <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            cap_valid <= mem_rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_reg <= img_size;
                        c_reg <= channels;
                        if (start_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                            rd_row    <= '0;
                            rd_col    <= '0;
                            wr_row    <= '0;
                            wr_col    <= '0;
                            win_ch    <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (mem_rd_en) begin
                        if (rd_last) begin
                            mem_rd_en <= 1'b0;
                            rd_row    <= '0;
                            rd_col    <= '0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_WIDTH'(1);
                            if (rd_col == s_last) begin
                                rd_col <= '0;
                                rd_row <= rd_row + SW'(1);
                            end else begin
                                rd_col <= rd_col + SW'(1);
                            end
                        end
                    end
                    if (cap_valid) begin
                        if (wr_last) begin
                            wr_row    <= '0;
                            wr_col    <= '0;
                            state     <= EMIT;
                            win_valid <= 1'b1;
                            win_row   <= '0;
                            win_col   <= '0;
                            window    <= window_nxt;
                        end else if (wr_col == s_last) begin
                            wr_col <= '0;
                            wr_row <= wr_row + SW'(1);
                        end else begin
                            wr_col <= wr_col + SW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        window  <= window_nxt;
                        win_row <= nxt_row;
                        win_col <= nxt_col;
                        if (col_last && row_last) begin
                            win_valid <= 1'b0;
                            if (win_ch < c_reg - CW'(1)) begin
                                win_ch    <= win_ch + CW'(1);
                                state     <= LOAD;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
